// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 lane mux between 8 requesters, with ready/valid handoff.
// Optional multi-transfer grants are enabled by defining ARB_BURST_EN (BURST_LEN transfers max).
module mux8_rr_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic [7:0] gnt,
    output logic [2:0] select,
    output logic       out_valid,
    output logic       xfer
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] gnt_reg, gnt_next;
    logic [2:0] select_reg, select_next;
    logic [2:0] ptr_reg, ptr_next;
    logic [7:0] req_others;
    logic [2:0] select_inc;
    logic [3:0] idle_pick;
    logic [3:0] rot_pick;
    logic       end_grant;

    generate
        if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_len
            $error("mux8_rr_arbiter: BURST_LEN must be in 1..16");
        end
    endgenerate

    // Returns {found, index} of the first set bit scanning start, start+1, ... mod 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // The lane finishing its grant is not eligible to be re-granted in the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            assign req_others[gi] = req[gi] & (select_reg != 3'(gi));
        end
    endgenerate

    assign select_inc = select_reg + 3'd1;
    assign idle_pick  = rr_pick(req, ptr_reg);
    assign rot_pick   = rr_pick(req_others, select_inc);

    assign out_valid = (state_reg == GRANT) & req[select_reg];
    assign xfer      = out_valid & out_ready;
    assign gnt       = gnt_reg;
    assign select    = select_reg;

`ifdef ARB_BURST_EN
    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN - 1);
    logic [3:0] burst_cnt_reg, burst_cnt_next;

    assign end_grant = xfer & ~(burst_cnt_reg < BURST_MAX);

    always_comb begin
        burst_cnt_next = burst_cnt_reg;
        if (state_reg == IDLE) begin
            burst_cnt_next = 4'd0;
        end else if (xfer) begin
            burst_cnt_next = end_grant ? 4'd0 : burst_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_reg <= 4'd0;
        end else begin
            burst_cnt_reg <= burst_cnt_next;
        end
    end
`else
    assign end_grant = xfer;
`endif

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        select_next = select_reg;
        ptr_next    = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (idle_pick[3]) begin
                    state_next  = GRANT;
                    select_next = idle_pick[2:0];
                    gnt_next    = 8'd1 << idle_pick[2:0];
                end
            end
            GRANT: begin
                if (!req[select_reg]) begin
                    // Requester withdrew before transferring: release the mux.
                    ptr_next   = select_inc;
                    state_next = IDLE;
                    gnt_next   = 8'd0;
                end else if (end_grant) begin
                    ptr_next = select_inc;
                    if (rot_pick[3]) begin
                        select_next = rot_pick[2:0];
                        gnt_next    = 8'd1 << rot_pick[2:0];
                    end else begin
                        state_next = IDLE;
                        gnt_next   = 8'd0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            gnt_reg    <= 8'd0;
            select_reg <= 3'd0;
            ptr_reg    <= 3'd0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            select_reg <= select_next;
            ptr_reg    <= ptr_next;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed testbench for mux8_rr_arbiter with hand-computed expectations.
// Burst scenario is selected by ARB_BURST_EN, matching the design build.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic [7:0] gnt;
    logic [2:0] select;
    logic       out_valid;
    logic       xfer;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.BURST_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .gnt       (gnt),
        .select    (select),
        .out_valid (out_valid),
        .xfer      (xfer)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    int lane_seq [12];

    initial begin
        do_reset();
        check("reset_gnt", 32'(gnt), 32'h00);
        check("reset_select", 32'(select), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);

        // Single request on lane 3.
        req = 8'h08; out_ready = 1'b1; #1;
        check("t1_pre_xfer", 32'(xfer), 32'd0);
        tick();
        check("t1_gnt", 32'(gnt), 32'h08);
        check("t1_select", 32'(select), 32'd3);
        check("t1_xfer", 32'(xfer), 32'd1);
        tick();
        req = 8'h00; #1;
        check("t1_idle_gnt", 32'(gnt), 32'h00);
        check("t1_idle_xfer", 32'(xfer), 32'd0);

        // All lanes requesting: rotate 0..7,0 with a transfer every cycle.
        do_reset();
        req = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("t2_select_%0d", i), 32'(select), 32'(i % 8));
            check($sformatf("t2_xfer_%0d", i), 32'(xfer), 32'd1);
        end

        // Backpressure on lane 5 for three cycles.
        do_reset();
        req = 8'h20; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_hold_gnt_%0d", i), 32'(gnt), 32'h20);
            check($sformatf("t3_hold_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("t3_hold_xfer_%0d", i), 32'(xfer), 32'd0);
            tick();
        end
        out_ready = 1'b1; #1;
        check("t3_select", 32'(select), 32'd5);
        check("t3_xfer", 32'(xfer), 32'd1);
        tick();
        req = 8'h00; #1;
        check("t3_idle_gnt", 32'(gnt), 32'h00);

        // Withdrawal on lane 2, then pointer has moved past lane 2.
        do_reset();
        req = 8'h04; out_ready = 1'b0;
        tick();
        check("t4_gnt", 32'(gnt), 32'h04);
        req = 8'h00; #1;
        check("t4_wd_valid", 32'(out_valid), 32'd0);
        check("t4_wd_xfer", 32'(xfer), 32'd0);
        tick();
        check("t4_wd_gnt", 32'(gnt), 32'h00);
        req = 8'h0C; out_ready = 1'b1;
        tick();
        check("t4_regnt", 32'(gnt), 32'h08);
        check("t4_select", 32'(select), 32'd3);

        // Asynchronous reset mid-transfer.
        do_reset();
        req = 8'h40; out_ready = 1'b0;
        tick();
        check("t5_gnt", 32'(gnt), 32'h40);
        check("t5_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        rst_n = 1'b0; #1;
        check("t5_rst_gnt", 32'(gnt), 32'h00);
        check("t5_rst_select", 32'(select), 32'd0);
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_xfer", 32'(xfer), 32'd0);
        rst_n = 1'b1;
        req = 8'hFF; #1;
        tick();
        check("t5_ptr_gnt", 32'(gnt), 32'h01);

        // Two requesters on lanes 1 and 6.
        do_reset();
        req = 8'h42; out_ready = 1'b1;
`ifdef ARB_BURST_EN
        lane_seq = '{1, 1, 1, 1, 6, 6, 6, 6, 1, 1, 1, 1};
`else
        lane_seq = '{1, 6, 1, 6, 1, 6, 1, 6, 1, 6, 1, 6};
`endif
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("t6_select_%0d", i), 32'(select), 32'(lane_seq[i]));
            check($sformatf("t6_xfer_%0d", i), 32'(xfer), 32'd1);
        end
        req = 8'h00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
